// File: rtl/magnetron_pwm.sv
// rtl/magnetron_pwm.sv - slot-based duty-cycle drive for a magnetron (optional MAGNETRON_SOFT_START_EN)
// A frame is FRAME_SLOTS slots of SLOT_CYCLES cycles each; the magnetron is driven for the first level_active slots.
module magnetron_pwm #(
    parameter int SLOT_CYCLES = 1000,
    parameter int FRAME_SLOTS = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       door_open,
    input  logic [2:0] level_in,
    output logic       magnetron_on,
    output logic [2:0] level_active,
    output logic       frame_start,
    output logic       busy
);

    localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [2:0]    SLOT_LAST = 3'(FRAME_SLOTS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [2:0]    slot_q, slot_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    level_q, level_d;
    logic          frame_start_q, frame_start_d;
    logic          drive_q, drive_d;
    logic [2:0]    eff_level_d;

`ifdef MAGNETRON_SOFT_START_EN
    logic          soft_q, soft_d;
`endif

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        cyc_d         = cyc_q;
        level_d       = level_q;
        frame_start_d = 1'b0;
`ifdef MAGNETRON_SOFT_START_EN
        soft_d        = soft_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // door must be closed to start; run and door rising together stays here
                if (run && !door_open) begin
                    state_d       = ST_RUN;
                    slot_d        = 3'd0;
                    cyc_d         = '0;
                    level_d       = level_in;
                    frame_start_d = 1'b1;
`ifdef MAGNETRON_SOFT_START_EN
                    soft_d        = 1'b1;
`endif
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_d = ST_IDLE;
                    slot_d  = 3'd0;
                    cyc_d   = '0;
                    level_d = 3'd0;
`ifdef MAGNETRON_SOFT_START_EN
                    soft_d  = 1'b0;
`endif
                end else if (door_open) begin
                    state_d = ST_PAUSE;
`ifdef MAGNETRON_SOFT_START_EN
                    soft_d  = 1'b0;
`endif
                end else if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (slot_q == SLOT_LAST) begin
                        slot_d        = 3'd0;
                        level_d       = level_in;
                        frame_start_d = 1'b1;
`ifdef MAGNETRON_SOFT_START_EN
                        soft_d        = 1'b0;
`endif
                    end else begin
                        slot_d = slot_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            ST_PAUSE: begin
                if (!run) begin
                    state_d = ST_IDLE;
                    slot_d  = 3'd0;
                    cyc_d   = '0;
                    level_d = 3'd0;
`ifdef MAGNETRON_SOFT_START_EN
                    soft_d  = 1'b0;
`endif
                end else if (!door_open) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = 3'd0;
                cyc_d   = '0;
                level_d = 3'd0;
            end
        endcase

`ifdef MAGNETRON_SOFT_START_EN
        eff_level_d = (soft_d && level_d > 3'd3) ? 3'd3 : level_d;
`else
        eff_level_d = level_d;
`endif
        // computed from next-state values so the drive lines up with the slot it belongs to
        drive_d = (state_d == ST_RUN) && (slot_d < eff_level_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            slot_q        <= 3'd0;
            cyc_q         <= '0;
            level_q       <= 3'd0;
            frame_start_q <= 1'b0;
            drive_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            cyc_q         <= cyc_d;
            level_q       <= level_d;
            frame_start_q <= frame_start_d;
            drive_q       <= drive_d;
        end
    end

`ifdef MAGNETRON_SOFT_START_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) soft_q <= 1'b0;
        else        soft_q <= soft_d;
    end
`endif

    assign magnetron_on = drive_q & ~door_open;
    assign level_active = level_q;
    assign frame_start  = frame_start_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_magnetron_pwm.sv
// tb/tb_magnetron_pwm.sv - self-checking bench for magnetron_pwm with SLOT_CYCLES=4 (28-cycle frame)
module tb_magnetron_pwm;

    localparam int SC    = 4;
    localparam int FRAME = 7 * SC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       door_open = 1'b0;
    logic [2:0] level_in = 3'd0;
    logic       magnetron_on;
    logic [2:0] level_active;
    logic       frame_start;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    magnetron_pwm #(.SLOT_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .door_open(door_open),
        .level_in(level_in), .magnetron_on(magnetron_on),
        .level_active(level_active), .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    // mode: 0 idle, 1 running, 2 paused; pos is the linear cycle position inside the frame
    int m_mode  = 0;
    int m_pos   = 0;
    int m_lvl   = 0;
    bit m_fs    = 1'b0;
    bit m_first = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_pos = 0; m_lvl = 0; m_fs = 0; m_first = 0;
        end else begin
            m_fs = 0;
            if (m_mode == 0) begin
                if (run && !door_open) begin
                    m_mode = 1; m_pos = 0; m_lvl = level_in; m_fs = 1; m_first = 1;
                end
            end else if (!run) begin
                m_mode = 0; m_pos = 0; m_lvl = 0; m_first = 0;
            end else if (m_mode == 1) begin
                if (door_open) begin
                    m_mode = 2; m_first = 0;
                end else if (m_pos == FRAME - 1) begin
                    m_pos = 0; m_lvl = level_in; m_fs = 1; m_first = 0;
                end else begin
                    m_pos = m_pos + 1;
                end
            end else if (!door_open) begin
                m_mode = 1;
            end
        end
    end

    function automatic int eff_level();
`ifdef MAGNETRON_SOFT_START_EN
        return (m_first && m_lvl > 3) ? 3 : m_lvl;
`else
        return m_lvl;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_on", int'(magnetron_on),
                  int'(m_mode == 1 && (m_pos / SC) < eff_level() && !door_open));
            check("model_level", int'(level_active), m_lvl);
            check("model_fs", int'(frame_start), int'(m_fs));
            check("model_busy", int'(busy), int'(m_mode != 0));
        end
    end

    task automatic count(input int n, output int on, output int fs);
        on = 0; fs = 0;
        repeat (n) begin
            @(negedge clk);
            on += int'(magnetron_on);
            fs += int'(frame_start);
            @(posedge clk); #1;
        end
    endtask

    task automatic start(input int lvl);
        level_in = 3'(lvl);
        run = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic stop();
        run = 1'b0;
        @(posedge clk); #1;
    endtask

    int on, fs;
`ifdef MAGNETRON_SOFT_START_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    initial begin
        #3;
        check("rst_on", int'(magnetron_on), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fs", int'(frame_start), 0);
        check("rst_level", int'(level_active), 0);
        cmp_en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // level 3: 12 on, 16 off, repeating
        start(3);
        check("l3_first_fs", int'(frame_start), 1);
        count(FRAME, on, fs); check("l3_on_f1", on, 12); check("l3_fs_f1", fs, 1);
        count(FRAME, on, fs); check("l3_on_f2", on, 12); check("l3_fs_f2", fs, 1);
        stop();
        check("idle_busy", int'(busy), 0);

        // run and door together in idle: stay idle
        door_open = 1'b1; run = 1'b1; level_in = 3'd7;
        count(5, on, fs); check("door_start_fs", fs, 0); check("door_start_busy", int'(busy), 0);
        door_open = 1'b0;
        @(posedge clk); #1;
        count(3 * FRAME, on, fs);
        check("l7_on", on, SOFT ? 12 + 2 * FRAME : 3 * FRAME); check("l7_fs", fs, 3);
        stop();

        start(0);
        count(3 * FRAME, on, fs); check("l0_on", on, 0); check("l0_fs", fs, 3);
        stop();

        // level 5 with door open cycles 6..15
        start(5);
        count(6, on, fs); check("p_on_pre", on, 6);
        door_open = 1'b1;
        count(10, on, fs); check("p_on_door", on, 0); check("p_busy", int'(busy), 1);
        door_open = 1'b0;
        count(1, on, fs); check("p_on_resume_gap", on, 0);
        count(14, on, fs); check("p_on_post", on, 14); check("p_fs_post", fs, 0);
        count(1, on, fs); check("p_off_phase", on, 0);
        door_open = 1'b1;
        count(2, on, fs);
        run = 1'b0;
        @(posedge clk); #1;
        check("pause_to_idle_busy", int'(busy), 0);
        door_open = 1'b0;

        // level change mid-frame takes effect at the next frame
        start(2);
        count(10, on, fs); check("lc_on_pre", on, 8);
        level_in = 3'd6;
        count(17, on, fs); check("lc_on_rest", on, 0);
        check("lc_level_c27", int'(level_active), 2);
        count(1, on, fs);
        check("lc_level_c28", int'(level_active), 6);
        count(FRAME, on, fs); check("lc_on_f2", on, 24); check("lc_fs_f2", fs, 1);
        stop();

        // asynchronous reset mid-frame
        start(4);
        count(5, on, fs);
        rst_n = 1'b0;
        #1;
        check("ar_on", int'(magnetron_on), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_level", int'(level_active), 0);
        check("ar_fs", int'(frame_start), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ar_restart_fs", int'(frame_start), 1);
        check("ar_restart_level", int'(level_active), 4);
        count(FRAME, on, fs); check("ar_on_frame", on, SOFT ? 12 : 16); check("ar_fs_frame", fs, 1);
        stop();

        // soft start comparison
        start(6);
        count(FRAME, on, fs); check("ss_on_f1", on, SOFT ? 12 : 24);
        count(FRAME, on, fs); check("ss_on_f2", on, 24);
        stop();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/magnetron_pwm.md
MAGNETRON_PWM -- requirements
Module: magnetron_pwm

Interface
REQ-001 Parameter SLOT_CYCLES, default 1000, clock cycles per power slot; legal range 2..65535.
REQ-002 Parameter FRAME_SLOTS, fixed 7, slots per duty frame (one per nonzero 3-bit level).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 run  input  1  cooking requested by the control FSM; level-sensitive.
REQ-006 door_open  input  1  door interlock; 1 = open.
REQ-007 level_in  input  3  binary power level 0..7 from the BCD-to-binary stage.
REQ-008 magnetron_on  output  1  magnetron drive; 1 = energised.
REQ-009 level_active  output  3  level latched for the current frame.
REQ-010 frame_start  output  1  one-cycle pulse on the first cycle of every frame.
REQ-011 busy  output  1  1 in RUN or PAUSE.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and PAUSE, with registered state.
REQ-013 IDLE->RUN on run=1 and door_open=0: clear slot_cnt (0..6) and cyc_cnt (0..SLOT_CYCLES-1), latch level_in into level_active, pulse frame_start.
REQ-014 In RUN, cyc_cnt SHALL increment each cycle; at SLOT_CYCLES-1 it wraps to 0 and slot_cnt increments.
REQ-015 At slot_cnt=6 and cyc_cnt=SLOT_CYCLES-1, both counters wrap to 0, level_in is relatched and frame_start pulses on the next cycle.
REQ-016 Registered drive SHALL be 1 in RUN when slot_cnt < level_active; duty is level/7.
REQ-017 Level 0 SHALL never energise; level 7 SHALL energise for the whole frame with no gap at frame wrap.
REQ-018 magnetron_on SHALL equal registered drive AND NOT door_open, gated combinationally with zero-cycle latency.
REQ-019 RUN->PAUSE on door_open=1; counters and level_active freeze.
REQ-020 PAUSE->RUN on door_open=0 and run=1, resuming from the frozen counts with no frame_start pulse.
REQ-021 RUN or PAUSE->IDLE on run=0, which has priority over door_open; counters clear and level_active goes to 0.
REQ-022 level_in changes mid-frame SHALL have no effect until the next frame boundary.
REQ-023 run and door_open rising in the same cycle in IDLE SHALL keep the FSM in IDLE.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, counters to 0, level_active=0, frame_start=0, busy=0 and magnetron_on=0.
REQ-025 Reset asserted mid-frame SHALL discard all progress; after release the block waits in IDLE for run.
REQ-026 Deassertion SHALL take effect on the first rising clk edge after rst_n returns high.

Configuration
REQ-027 Macro MAGNETRON_SOFT_START_EN:
- Defined: the first frame after each IDLE->RUN entry uses an effective level of min(level_active, 3); later frames, and frames resumed from PAUSE, use full level_active.
- Undefined: no cap, and the soft-start logic is absent.
- level_active always reports the latched, uncapped level.

Verification (SLOT_CYCLES=4, frame = 28 cycles)
REQ-028 Reset, then run=1 with level_in=3 -> frame_start pulses once; magnetron_on high for 12 cycles then low for 16 cycles; repeats every 28 cycles.
REQ-029 level_in=7 -> magnetron_on continuously high across three frames; level_in=0 -> never high; frame_start pulses every 28 cycles in both cases.
REQ-030 level_in=5, door_open=1 at cycle 6 for 10 cycles -> magnetron_on drops in cycle 6, busy stays 1; on resume, 14 more on-cycles before the off phase.
REQ-031 level_in changes 2->6 at cycle 10 -> first frame has 8 on-cycles, second frame 24; level_active reads 6 only from cycle 28.
REQ-032 rst_n pulsed low at cycle 5 of a level-4 frame -> all outputs 0 within that cycle; run still 1 after release -> new frame starts from slot 0.
REQ-033 With MAGNETRON_SOFT_START_EN, level_in=6 -> first frame 12 on-cycles, second frame 24; without the macro, both frames 24.
